imem_loader: RTL and testbench

Boot-time writer for the single-cycle core's instruction memory. It accepts a byte stream over a valid/ready handshake, checks a word-count header, assembles little-endian 32-bit instructions, and drives the instruction memory write port word by word. A trailing checksum byte validates the payload. The core is held in reset until a load completes successfully.

---
 rtl/imem_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader for the core's instruction memory.
// Receives a 4-byte little-endian word-count header, N little-endian payload
// words and a mod-256 checksum byte, writes each word as it completes, and
// holds the core in reset until a session finishes with a matching checksum.
module imem_loader #(
    parameter int MEM_SIZE = 1024
) (
    input  logic        Clk_Core,
    input  logic        Rst_Core,
    input  logic        Load_Start,
    input  logic        Byte_Valid,
    input  logic [7:0]  Byte_Data,
    output logic        Byte_Ready,
    output logic        Mem_Wr_En,
    output logic [31:0] Mem_Wr_Addr,
    output logic [31:0] Mem_Wr_Data,
    output logic        Core_Hold,
    output logic        Load_Busy,
    output logic        Load_Done,
    output logic        Load_Error
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_next_s;

    logic [1:0]  byte_cnt_r;     // byte position within the current header/word
    logic [23:0] byte_buf_r;     // lower three bytes of the word being assembled
    logic [31:0] word_cnt_r;     // N taken from the header
    logic [31:0] word_idx_r;     // index of the next word to be written
    logic [7:0]  csum_r;         // running payload sum, wraps mod 256

    logic        ready_r;
    logic        wr_en_r;
    logic [31:0] wr_addr_r;
    logic [31:0] wr_data_r;
    logic        hold_r;
    logic        busy_r;
    logic        done_r;
    logic        err_r;

    logic        accept_s;
    logic        start_s;
    logic        last_byte_s;
    logic        last_word_s;
    logic        hdr_bad_s;
    logic [31:0] full_word_s;

    assign accept_s    = Byte_Valid & ready_r;
    assign last_byte_s = (byte_cnt_r == 2'd3);
    assign full_word_s = {Byte_Data, byte_buf_r};
    assign hdr_bad_s   = (full_word_s == 32'd0) || (full_word_s > 32'(MEM_SIZE));
    assign last_word_s = (word_idx_r == (word_cnt_r - 32'd1));
    // A session may only be (re)started from a quiescent state.
    assign start_s     = Load_Start &&
                         ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR));

    // State register.
    always_ff @(posedge Clk_Core or posedge Rst_Core) begin
        if (Rst_Core) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_s) begin
                    state_next_s = ST_HDR;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_HDR: begin
                if (accept_s && last_byte_s) begin
                    state_next_s = hdr_bad_s ? ST_ERR : ST_DATA;
                end else begin
                    state_next_s = ST_HDR;
                end
            end
            ST_DATA: begin
                if (accept_s && last_byte_s && last_word_s) begin
                    state_next_s = ST_CSUM;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (accept_s) begin
                    state_next_s = (Byte_Data == csum_r) ? ST_DONE : ST_ERR;
                end else begin
                    state_next_s = ST_CSUM;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Byte assembly, header capture, checksum and memory write strobe.
    always_ff @(posedge Clk_Core or posedge Rst_Core) begin
        if (Rst_Core) begin
            byte_cnt_r <= 2'd0;
            byte_buf_r <= 24'd0;
            word_cnt_r <= 32'd0;
            word_idx_r <= 32'd0;
            csum_r     <= 8'd0;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= 32'd0;
            wr_data_r  <= 32'd0;
        end else begin
            wr_en_r <= 1'b0;
            if (start_s) begin
                byte_cnt_r <= 2'd0;
                byte_buf_r <= 24'd0;
                word_cnt_r <= 32'd0;
                word_idx_r <= 32'd0;
                csum_r     <= 8'd0;
            end else if (accept_s) begin
                byte_cnt_r <= byte_cnt_r + 2'd1;
                byte_buf_r <= {Byte_Data, byte_buf_r[23:8]};
                case (state_r)
                    ST_HDR: begin
                        if (last_byte_s) begin
                            word_cnt_r <= full_word_s;
                        end
                    end
                    ST_DATA: begin
                        csum_r <= csum_r + Byte_Data;
                        if (last_byte_s) begin
                            wr_en_r    <= 1'b1;
                            wr_addr_r  <= {word_idx_r[29:0], 2'b00};
                            wr_data_r  <= full_word_s;
                            word_idx_r <= word_idx_r + 32'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Status outputs registered from the upcoming state so they line up with it.
    always_ff @(posedge Clk_Core or posedge Rst_Core) begin
        if (Rst_Core) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            hold_r  <= 1'b1;
        end else begin
            ready_r <= (state_next_s == ST_HDR) || (state_next_s == ST_DATA) ||
                       (state_next_s == ST_CSUM);
            busy_r  <= (state_next_s == ST_HDR) || (state_next_s == ST_DATA) ||
                       (state_next_s == ST_CSUM);
            done_r  <= (state_next_s == ST_DONE);
            err_r   <= (state_next_s == ST_ERR);
            hold_r  <= (state_next_s != ST_DONE);
        end
    end

    assign Byte_Ready  = ready_r;
    assign Mem_Wr_En   = wr_en_r;
    assign Mem_Wr_Addr = wr_addr_r;
    assign Mem_Wr_Data = wr_data_r;
    assign Core_Hold   = hold_r;
    assign Load_Busy   = busy_r;
    assign Load_Done   = done_r;
    assign Load_Error  = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        core_hold;
    logic        load_busy;
    logic        load_done;
    logic        load_error;

    int checks = 0;
    int errors = 0;

    logic [31:0] imem [0:1023];
    int          wr_count = 0;
    logic [31:0] last_addr = 32'd0;
    logic [31:0] last_data = 32'd0;

    imem_loader #(.MEM_SIZE(1024)) dut (
        .Clk_Core    (clk),
        .Rst_Core    (rst),
        .Load_Start  (load_start),
        .Byte_Valid  (byte_valid),
        .Byte_Data   (byte_data),
        .Byte_Ready  (byte_ready),
        .Mem_Wr_En   (mem_wr_en),
        .Mem_Wr_Addr (mem_wr_addr),
        .Mem_Wr_Data (mem_wr_data),
        .Core_Hold   (core_hold),
        .Load_Busy   (load_busy),
        .Load_Done   (load_done),
        .Load_Error  (load_error)
    );

    always #5 clk = ~clk;

    // Instruction memory model: captures each write strobe shortly after the edge.
    always @(posedge clk) begin
        #2;
        if (mem_wr_en) begin
            wr_count++;
            last_addr = mem_wr_addr;
            last_data = mem_wr_data;
            imem[mem_wr_addr[11:2]] = mem_wr_data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one byte after an optional idle gap and wait for it to be accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int tries;
        repeat (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        tries = 0;
        while (!byte_ready && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 20) begin
            check_eq("ready_timeout", 32'(byte_ready), 32'd1);
            byte_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gappy);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], gappy ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0) : 0);
        end
    endtask

    task automatic start_load();
        @(negedge clk);
        byte_valid = 1'b0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic end_stream();
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    initial begin
        int          base;
        logic [7:0]  sum;
        logic [31:0] w;
        logic [31:0] pc;

        // Reset state
        #12;
        check_eq("rst_ready", 32'(byte_ready), 32'd0);
        check_eq("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check_eq("rst_addr", mem_wr_addr, 32'd0);
        check_eq("rst_data", mem_wr_data, 32'd0);
        check_eq("rst_hold", 32'(core_hold), 32'd1);
        check_eq("rst_busy", 32'(load_busy), 32'd0);
        check_eq("rst_done", 32'(load_done), 32'd0);
        check_eq("rst_error", 32'(load_error), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_ready", 32'(byte_ready), 32'd0);

        // Good load, N=2
        start_load();
        check_eq("hdr_ready", 32'(byte_ready), 32'd1);
        check_eq("hdr_busy", 32'(load_busy), 32'd1);
        base = wr_count;
        send_word(32'd2, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        end_stream();
        check_eq("w0_en", 32'(mem_wr_en), 32'd1);
        check_eq("w0_addr", mem_wr_addr, 32'h0);
        check_eq("w0_data", mem_wr_data, 32'h0000_0013);
        send_word(32'h0010_0093, 1'b0);
        end_stream();
        check_eq("w1_en", 32'(mem_wr_en), 32'd1);
        check_eq("w1_addr", mem_wr_addr, 32'h4);
        check_eq("w1_data", mem_wr_data, 32'h0010_0093);
        check_eq("csum_ready", 32'(byte_ready), 32'd1);
        send_byte(8'hB6, 0);
        end_stream();
        check_eq("good_done", 32'(load_done), 32'd1);
        check_eq("good_hold", 32'(core_hold), 32'd0);
        check_eq("good_error", 32'(load_error), 32'd0);
        check_eq("good_busy", 32'(load_busy), 32'd0);
        check_eq("good_wr_en_off", 32'(mem_wr_en), 32'd0);
        check_eq("good_addr_hold", mem_wr_addr, 32'h4);
        check_eq("good_writes", 32'(wr_count - base), 32'd2);
        check_eq("good_mem0", imem[0], 32'h0000_0013);
        check_eq("good_mem1", imem[1], 32'h0010_0093);

        // Bad checksum
        start_load();
        base = wr_count;
        send_word(32'd2, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_0093, 1'b0);
        send_byte(8'hB7, 0);
        end_stream();
        check_eq("bad_error", 32'(load_error), 32'd1);
        check_eq("bad_done", 32'(load_done), 32'd0);
        check_eq("bad_hold", 32'(core_hold), 32'd1);
        check_eq("bad_ready", 32'(byte_ready), 32'd0);
        check_eq("bad_writes", 32'(wr_count - base), 32'd2);

        // Illegal count N=0
        start_load();
        base = wr_count;
        send_word(32'd0, 1'b0);
        end_stream();
        check_eq("n0_error", 32'(load_error), 32'd1);
        check_eq("n0_busy", 32'(load_busy), 32'd0);
        check_eq("n0_ready", 32'(byte_ready), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("n0_writes", 32'(wr_count - base), 32'd0);

        // Illegal count N=1025
        start_load();
        base = wr_count;
        send_word(32'd1025, 1'b0);
        end_stream();
        check_eq("n1025_error", 32'(load_error), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("n1025_writes", 32'(wr_count - base), 32'd0);

        // Recovery: valid N=1 load, checksum AA+BB+CC+DD = 0x30E -> 0x0E
        start_load();
        base = wr_count;
        send_word(32'd1, 1'b0);
        send_word(32'hDDCC_BBAA, 1'b0);
        send_byte(8'h0E, 0);
        end_stream();
        check_eq("recov_done", 32'(load_done), 32'd1);
        check_eq("recov_mem0", imem[0], 32'hDDCC_BBAA);
        check_eq("recov_writes", 32'(wr_count - base), 32'd1);

        // Full load, N=1024, word i = i*4, gapped valid
        for (int i = 0; i < 1024; i++) imem[i] = 32'hDEAD_BEEF;
        start_load();
        base = wr_count;
        sum = 8'd0;
        send_word(32'd1024, 1'b1);
        for (int i = 0; i < 1024; i++) begin
            w = 32'(i) * 32'd4;
            sum = sum + w[7:0] + w[15:8] + w[23:16] + w[31:24];
            send_word(w, 1'b1);
        end
        send_byte(sum, 1);
        end_stream();
        check_eq("full_writes", 32'(wr_count - base), 32'd1024);
        check_eq("full_last_addr", last_addr, 32'h0000_0FFC);
        check_eq("full_last_data", last_data, 32'h0000_0FFC);
        check_eq("full_done", 32'(load_done), 32'd1);
        check_eq("full_hold", 32'(core_hold), 32'd0);
        for (int i = 0; i < 1024; i++) begin
            pc = 32'(i) * 32'd4;
            check_eq("full_readback", imem[pc[11:2]], pc);
        end

        // Reset mid-DATA after header plus 6 payload bytes
        start_load();
        base = wr_count;
        send_word(32'd2, 1'b0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        end_stream();
        check_eq("mid_busy", 32'(load_busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_ready", 32'(byte_ready), 32'd0);
        check_eq("arst_wr_en", 32'(mem_wr_en), 32'd0);
        check_eq("arst_addr", mem_wr_addr, 32'd0);
        check_eq("arst_data", mem_wr_data, 32'd0);
        check_eq("arst_hold", 32'(core_hold), 32'd1);
        check_eq("arst_busy", 32'(load_busy), 32'd0);
        check_eq("arst_done", 32'(load_done), 32'd0);
        check_eq("arst_error", 32'(load_error), 32'd0);
        check_eq("mid_writes", 32'(wr_count - base), 32'd1);
        check_eq("mid_mem0", imem[0], 32'h4433_2211);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("post_rst_writes", 32'(wr_count - base), 32'd1);
        // Fresh N=1 load, checksum 78+56+34+12 = 0x114 -> 0x14
        start_load();
        send_word(32'd1, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        send_byte(8'h14, 0);
        end_stream();
        check_eq("fresh_done", 32'(load_done), 32'd1);
        check_eq("fresh_writes", 32'(wr_count - base), 32'd2);
        check_eq("fresh_addr", last_addr, 32'h0);
        check_eq("fresh_mem0", imem[0], 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
